// File: rtl/lsu_pkg.sv
// Shared constants for the load/store alignment slice.
// No logic here, so no latency.
// No flow control: constants only.
//
// Contents: RISC-V funct3 encodings for byte, halfword and word accesses,
// signed and unsigned. Every other funct3 value is treated as invalid.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ld_lane_extract.sv
// Load lane extractor: selects the addressed byte/halfword/word and extends it.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   i_rdata  [31:0]  word returned by memory
//   i_off    [1:0]   byte offset of the access
//   i_funct3 [2:0]   access size and signedness
//   i_load           access is a load; result is forced to 0 otherwise
//   o_data   [31:0]  extended load result
module ld_lane_extract (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic        i_load,
  output logic [31:0] o_data
);
  import lsu_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (i_off)
      2'd0:    byte_v = i_rdata[7:0];
      2'd1:    byte_v = i_rdata[15:8];
      2'd2:    byte_v = i_rdata[23:16];
      default: byte_v = i_rdata[31:24];
    endcase

    // Halfword selection uses only off[1]. A misaligned off[0] is ignored
    // here; it is flagged separately by the top level.
    half_v = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = 32'h0000_0000;
    if (i_load) begin
      case (i_funct3)
        F3_B:    o_data = {{24{byte_v[7]}}, byte_v};
        F3_BU:   o_data = {24'h00_0000, byte_v};
        F3_H:    o_data = {{16{half_v[15]}}, half_v};
        F3_HU:   o_data = {16'h0000, half_v};
        F3_W:    o_data = i_rdata;
        default: o_data = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/ld_st_align_unit.sv
// RV32 byte-lane alignment between the pipeline and a 32-bit word memory.
// Latency: store path 0 cycles (combinational); load path 1 cycle.
// Backpressure: none; memory is assumed to return read data one cycle after the address.
//
// Ports:
//   i_clk, i_reset            clock; asynchronous active-high reset
//   i_addr [31:0]             byte address (only [1:0] matter)
//   i_funct3 [2:0], i_load    access type of the current instruction
//   i_st_data -> o_st_data    lane-aligned store data
//   o_bmask [3:0]             per-byte write enable (0 when misaligned or invalid)
//   i_rdata -> o_ld_data      extended load result for last cycle's load
//   o_misaligned              current access is misaligned
module ld_st_align_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_load,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_bmask,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned
);
  import lsu_pkg::*;

  logic [1:0]  off;
  logic        unused_addr;
  logic        misaligned;
  logic [31:0] st_data;
  logic [3:0]  bmask;

  logic [2:0]  funct3_d, funct3_q;
  logic        load_d,   load_q;
  logic [1:0]  off_d,    off_q;

  assign off         = i_addr[1:0];
  assign unused_addr = ^i_addr[31:2];

  // Misalignment is a property of size and offset only; loads and stores
  // share the same rule, and invalid encodings are never misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Store path. Data always follows the shift rule even when the mask is
  // cleared, so a misaligned store is suppressed purely through o_bmask.
  always_comb begin
    st_data = i_st_data;
    bmask   = 4'b0000;
    case (i_funct3)
      F3_B: begin
        st_data = {24'h00_0000, i_st_data[7:0]} << {off, 3'b000};
        bmask   = 4'b0001 << off;
      end
      F3_H: begin
        st_data = {16'h0000, i_st_data[15:0]} << {off[1], 4'b0000};
        bmask   = off[1] ? 4'b1100 : 4'b0011;
        if (misaligned) bmask = 4'b0000;
      end
      F3_W: begin
        st_data = i_st_data;
        bmask   = misaligned ? 4'b0000 : 4'b1111;
      end
      default: begin
        st_data = i_st_data;
        bmask   = 4'b0000;
      end
    endcase
  end

  assign o_st_data    = st_data;
  assign o_bmask      = bmask;
  assign o_misaligned = misaligned;

  // Load controls are sampled every edge; the memory returns data for this
  // address one cycle later, when these registers line up with i_rdata.
  assign funct3_d = i_funct3;
  assign load_d   = i_load;
  assign off_d    = off;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      funct3_q <= 3'b000;
      load_q   <= 1'b0;
      off_q    <= 2'b00;
    end else begin
      funct3_q <= funct3_d;
      load_q   <= load_d;
      off_q    <= off_d;
    end
  end

  // Clearing load_q on reset forces o_ld_data to 0 without a clock.
  ld_lane_extract u_ld_lane_extract (
    .i_rdata  (i_rdata),
    .i_off    (off_q),
    .i_funct3 (funct3_q),
    .i_load   (load_q),
    .o_data   (o_ld_data)
  );

endmodule

// File: tb/tb_ld_st_align_unit.sv
module tb_ld_st_align_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_addr;
  logic [2:0]  i_funct3;
  logic        i_load;
  logic [31:0] i_st_data;
  logic [31:0] o_st_data;
  logic [3:0]  o_bmask;
  logic [31:0] i_rdata;
  logic [31:0] o_ld_data;
  logic        o_misaligned;

  ld_st_align_unit dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_addr       (i_addr),
    .i_funct3     (i_funct3),
    .i_load       (i_load),
    .i_st_data    (i_st_data),
    .o_st_data    (o_st_data),
    .o_bmask      (o_bmask),
    .i_rdata      (i_rdata),
    .o_ld_data    (o_ld_data),
    .o_misaligned (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] st;
    logic [3:0]  bm;
    bit          mis;
    bit          fix_en;
    logic [31:0] fix;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Controls the model believes are captured for the in-flight load.
  bit       p_ld;
  int       p_f3;
  int       p_off;

  localparam logic [31:0] R = 32'h80FF7F01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result: pick the addressed unit arithmetically, then extend.
  function automatic logic [31:0] m_ld(input bit ld, input int f3, input int off, input logic [31:0] r);
    int unsigned b, h;
    if (!ld) return 32'h0;
    b = (r >> (8 * off)) & 32'hFF;
    h = (r >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      4:       return 32'(b);
      1:       return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      5:       return 32'(h);
      2:       return r;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_st(input int f3, input int off, input logic [31:0] d,
                      output logic [31:0] st, output logic [3:0] bm, output bit mis);
    mis = ((f3 == 1 || f3 == 5) && (off % 2 == 1)) || (f3 == 2 && off != 0);
    case (f3)
      0: begin st = (d & 32'hFF) << (8 * off); bm = 4'(1 << off); end
      1: begin st = (d & 32'hFFFF) << (16 * (off / 2)); bm = mis ? 4'd0 : 4'(3 << (2 * (off / 2))); end
      2: begin st = d; bm = mis ? 4'd0 : 4'hF; end
      default: begin st = d; bm = 4'd0; end
    endcase
  endtask

  // One cycle of stimulus: rdata answers the previous access, controls start a new one.
  task automatic step(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] std, input logic [31:0] rdata,
                      input bit fix_en, input logic [31:0] fix);
    exp_t e;
    @(posedge i_clk); #1;
    i_rdata   = rdata;
    e.ld      = m_ld(p_ld, p_f3, p_off, rdata);
    i_load    = ld;
    i_funct3  = f3;
    i_addr    = addr;
    i_st_data = std;
    m_st(int'(f3), int'(addr[1:0]), std, e.st, e.bm, e.mis);
    e.fix_en  = fix_en;
    e.fix     = fix;
    q.push_back(e);
    p_ld  = ld;
    p_f3  = int'(f3);
    p_off = int'(addr[1:0]);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ld_data", o_ld_data, e.ld);
        chk("st_data", o_st_data, e.st);
        chk("bmask", {28'h0, o_bmask}, {28'h0, e.bm});
        chk("misaligned", {31'h0, o_misaligned}, {31'h0, e.mis});
        if (e.fix_en) chk("ld_data_directed", o_ld_data, e.fix);
      end
    end
  end

  initial begin
    logic [31:0] est;
    logic [3:0]  ebm;
    bit          emis;

    i_reset = 1'b1; i_addr = 32'h0; i_funct3 = 3'b0; i_load = 1'b0;
    i_st_data = 32'h0; i_rdata = 32'hFFFF_FFFF;
    p_ld = 1'b0; p_f3 = 0; p_off = 0;

    repeat (2) @(posedge i_clk);
    #2;
    chk("reset_ld_data", o_ld_data, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Directed store cases.
    step(1'b0, 3'b000, 32'h0000_0102, 32'h1234_56AB, 32'h0, 1'b0, 32'h0);
    step(1'b0, 3'b001, 32'h0000_0002, 32'hDEAD_1234, 32'h0, 1'b0, 32'h0);
    step(1'b0, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0);
    step(1'b0, 3'b010, 32'h0000_0001, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0);

    // Directed loads; each fixed value belongs to the controls of the previous step.
    step(1'b1, 3'b000, 32'h3, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 3'b100, 32'h3, 32'h0, R, 1'b1, 32'hFFFF_FF80);
    step(1'b1, 3'b000, 32'h2, 32'h0, R, 1'b1, 32'h0000_0080);
    step(1'b1, 3'b001, 32'h2, 32'h0, R, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 3'b101, 32'h2, 32'h0, R, 1'b1, 32'hFFFF_80FF);
    step(1'b1, 3'b001, 32'h0, 32'h0, R, 1'b1, 32'h0000_80FF);
    step(1'b1, 3'b010, 32'h0, 32'h0, R, 1'b1, 32'h0000_7F01);
    step(1'b0, 3'b000, 32'h1, 32'h0, R, 1'b1, 32'h80FF_7F01);
    step(1'b1, 3'b011, 32'h0, 32'h0, R, 1'b1, 32'h0);
    step(1'b1, 3'b010, 32'h0, 32'h0, R, 1'b1, 32'h0);
    step(1'b0, 3'b000, 32'h0, 32'h0, R, 1'b1, 32'h80FF_7F01);

    // Async reset between edges while the captured LW is still presented.
    @(negedge i_clk); #2;
    i_reset = 1'b1;
    #1;
    chk("async_reset_ld", o_ld_data, 32'h0);
    i_funct3 = 3'b000; i_addr = 32'h1; i_st_data = 32'h0000_00AA;
    #1;
    m_st(0, 1, 32'h0000_00AA, est, ebm, emis);
    chk("reset_st_data", o_st_data, est);
    chk("reset_bmask", {28'h0, o_bmask}, {28'h0, ebm});
    @(posedge i_clk); #1;
    chk("reset_hold_ld", o_ld_data, 32'h0);

    // Release mid-cycle with a word load pending: output stays 0 until the next edge.
    i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0; i_rdata = 32'h1122_3344;
    @(negedge i_clk); #2;
    i_reset = 1'b0;
    #1;
    chk("release_ld_before_edge", o_ld_data, 32'h0);
    p_ld = 1'b1; p_f3 = 2; p_off = 0;
    step(1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE);

    // Randomized traffic covering all funct3 codes, offsets and load gating.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
           $urandom, $urandom, 1'b0, 32'h0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge i_clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
